fp16_to_fixed_pipe: RTL and testbench
=====================================

// Module: fp16_to_fixed_pipe
// PURPOSE
//   Converts IEEE-754 binary16 values to unsigned Q0.FRAC_BITS fractions in [0,1).
//   This is the inverse of the Sobol path's integer-to-FP16 stage. It recovers
//   fixed-point samples from FP16 results for comparison, feedback and
//   checking. It is a 2-stage pipeline with valid/ready flow control on both
//   sides, and it carries one status-flag vector per sample.
// PARAMETERS
//   FRAC_BITS  32  output fraction width; legal range 16..32; out_val = round(x * 2^FRAC_BITS)
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          fp16_in is valid
//   in_ready   out  1          block accepts fp16_in this cycle
//   fp16_in    in   16         {sign, exp[4:0], man[9:0]}
//   out_valid  out  1          out_val/out_flags are valid
//   out_ready  in   1          downstream accepts this cycle
//   out_val    out  FRAC_BITS  unsigned Q0.FRAC_BITS result
//   out_flags  out  3          {nan, sat, neg}
// BEHAVIOUR
//   Reset:
//     - On clk edge with rst=1: s1_valid=0, out_valid=0, out_val=0, out_flags=0.
//     - Any in-flight data is dropped.
//     - in_ready=1 in the first cycle after reset.
//   Handshake:
//     - An input transfers when in_valid&&in_ready.
//     - An output transfers when out_valid&&out_ready.
//     - adv2 = ~out_valid | out_ready
//     - adv1 = ~s1_valid | adv2
//     - in_ready = adv1 (combinational; no in_valid dependence)
//     - While out_valid&&!out_ready, out_val and out_flags hold stable.
//     - Latency: 2 cycles from accept to out_valid with no stall.
//     - Throughput: 1 sample/cycle; no bubbles under continuous ready.
//   Stage 1 (decode, registered):
//     - e=exp, m=man.
//     - Classify: nan (e=31, m!=0); inf (e=31, m=0); zero (e=0, m=0);
//       subnormal (e=0, m!=0); normal otherwise.
//     - sig = normal ? {1,m} : {0,m} (11b).
//     - sh = (normal ? e : 1) - 25 + FRAC_BITS (signed 7b).
//   Stage 2 (shift/round/saturate, registered):
//     - If sh>=0: r = sig << sh (exact).
//     - If sh<0: r = sig >> -sh, rounded to nearest, ties to even.
//       - guard = bit -sh-1; sticky = OR of lower dropped bits.
//       - Increment if guard & (sticky | r[0]).
//       - Shifts >= 12 give r=0.
//     - Compute r at FRAC_BITS+1 bits so that overflow is detected.
//   Priority / result mapping:
//     1. nan               -> out_val=0,          flags=100
//     2. sign=1, nonzero   -> out_val=0,          flags=001 (includes -inf)
//     3. +inf, or r >= 2^FRAC_BITS (includes 1.0 and above)
//                          -> out_val=all ones,   flags=010
//     4. otherwise         -> out_val=r,          flags=000
//     - -0 (0x8000) gives out_val=0 with flags=000.
//     - Underflow to 0 through rounding is not flagged.
// TESTING (FRAC_BITS=32 unless stated)
//   - 0x3800 (0.5) -> out_val=0x80000000, flags=000, out_valid 2 cycles after accept.
//   - Full encoding checks, in this order:
//       0x3C00 -> 0xFFFFFFFF, flags=010
//       0x7C00 -> 0xFFFFFFFF, flags=010
//       0x7E00 -> 0,          flags=100
//       0xB800 -> 0,          flags=001
//       0x8000 -> 0,          flags=000
//       0x0001 -> 0x00000100, flags=000
//   - FRAC_BITS=16 rounding:
//       0x3555 -> 0x5550
//       0x1C01 -> 0x0100
//       0x1C02 -> 0x0100 (tie, even)
//       0x1C06 -> 0x0102 (tie, up)
//   - Backpressure: stream 8 values, hold out_ready=0 for 5 cycles mid-stream
//       -> in_ready drops once both stages are full;
//       -> out_val is stable throughout the stall;
//       -> all 8 results arrive in order, none lost or duplicated.
//   - Continuous in_valid=out_ready=1 for 16 samples -> 16 outputs on 16 consecutive cycles.
//   - Assert rst for 1 cycle with 2 samples in flight
//       -> next cycle out_valid=0, out_val=0, in_ready=1;
//       -> no stale sample is emitted afterwards.

Source files
------------

// File: rtl/fp16_to_fixed_pipe_if.sv
// Stream bundle for the FP16-to-fixed converter.
// Carries FP16 samples in and Q0.FRAC_BITS fractions with status flags out.
interface fp16_to_fixed_pipe_if #(
   parameter int FRAC_BITS = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [15:0]          fp16_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [FRAC_BITS-1:0] out_val;
   logic [2:0]           out_flags;

   modport slave (
      input  in_valid, fp16_in, out_ready,
      output in_ready, out_valid, out_val, out_flags
   );

   modport master (
      output in_valid, fp16_in, out_ready,
      input  in_ready, out_valid, out_val, out_flags
   );
endinterface

// File: rtl/fp16_to_fixed_pipe.sv
// Two-stage FP16 -> unsigned Q0.FRAC_BITS converter with valid/ready flow.
// Stage 1 decodes the encoding, stage 2 shifts, rounds and saturates.
module fp16_to_fixed_pipe #(
   parameter int FRAC_BITS = 32
) (
   input logic clk,
   input logic rst,
   fp16_to_fixed_pipe_if.slave bus
);
   typedef struct packed {
      logic        nan;
      logic        inf;
      logic        zero;
      logic        neg;
      logic [10:0] sig;
      logic [6:0]  sh;
   } s1_t;

   logic                 adv1;
   logic                 adv2;
   logic                 s1_valid;
   s1_t                  s1_d;
   s1_t                  s1_q;
   logic [4:0]           e;
   logic [9:0]           m;
   logic [4:0]           eff_e;
   logic                 normal;
   logic                 out_valid_q;
   logic [FRAC_BITS-1:0] out_val_q;
   logic [2:0]           out_flags_q;
   logic [63:0]          wide;
   logic [22:0]          dn;
   logic [6:0]           nsh;
   logic                 rnd_up;
   logic                 sat;
   logic [FRAC_BITS-1:0] val_d;
   logic [2:0]           flg_d;

   assign adv2         = ~out_valid_q | bus.out_ready;
   assign adv1         = ~s1_valid | adv2;
   assign bus.in_ready = adv1;
   assign bus.out_valid = out_valid_q;
   assign bus.out_val   = out_val_q;
   assign bus.out_flags = out_flags_q;

   always_comb begin
      e         = bus.fp16_in[14:10];
      m         = bus.fp16_in[9:0];
      normal    = 1'b0;
      s1_d.nan  = 1'b0;
      s1_d.inf  = 1'b0;
      s1_d.zero = 1'b0;
      s1_d.neg  = bus.fp16_in[15];
      unique case (1'b1)
         (e == 5'd31): begin
            s1_d.nan = |m;
            s1_d.inf = ~|m;
         end
         (e == 5'd0): s1_d.zero = ~|m;
         default:     normal = 1'b1;
      endcase
      s1_d.sig = {normal, m};
      eff_e    = normal ? e : 5'd1;
      s1_d.sh  = {2'b00, eff_e} + 7'(FRAC_BITS) - 7'd25;
   end

   // Negative shifts keep 12 dropped bits below the LSB for guard/sticky.
   always_comb begin
      wide   = '0;
      dn     = '0;
      rnd_up = 1'b0;
      nsh    = -s1_q.sh;
      if (!s1_q.sh[6]) begin
         wide = {53'd0, s1_q.sig} << s1_q.sh[5:0];
      end else begin
         dn     = {s1_q.sig, 12'd0} >> nsh;
         rnd_up = dn[11] & ((|dn[10:0]) | dn[12]);
         wide   = {53'd0, dn[22:12]} + {63'd0, rnd_up};
      end
      sat   = s1_q.inf | (|wide[63:FRAC_BITS]);
      val_d = wide[FRAC_BITS-1:0];
      flg_d = 3'b000;
      if (s1_q.nan) begin
         val_d = '0;
         flg_d = 3'b100;
      end else if (s1_q.neg && !s1_q.zero) begin
         val_d = '0;
         flg_d = 3'b001;
      end else if (sat) begin
         val_d = '1;
         flg_d = 3'b010;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         out_val_q   <= '0;
         out_flags_q <= '0;
      end else begin
         if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) s1_q <= s1_d;
         end
         if (adv2) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
               out_val_q   <= val_d;
               out_flags_q <= flg_d;
            end
         end
      end
   end
endmodule

// File: tb/tb_fp16_to_fixed_pipe.sv
// Bench for fp16_to_fixed_pipe: directed vectors at FRAC_BITS=32 and 16,
// plus random streams scored against a real-arithmetic reference model.
`timescale 1ns/1ps
module tb_fp16_to_fixed_pipe;
   typedef struct {
      logic [15:0] h;
      logic [63:0] v;
      logic [2:0]  f;
      int          sel;
   } vec_t;

   typedef struct {
      logic [63:0] v;
      logic [2:0]  f;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   res_t        sb32[$];
   res_t        sb16[$];
   bit          hold[2];
   logic [63:0] hv[2];
   logic [2:0]  hf[2];
   int          outs[2];

   always #5 clk = ~clk;

   fp16_to_fixed_pipe_if #(.FRAC_BITS(32)) b32 ();
   fp16_to_fixed_pipe_if #(.FRAC_BITS(16)) b16 ();

   fp16_to_fixed_pipe #(.FRAC_BITS(32)) dut32 (
      .clk(clk), .rst(rst), .bus(b32)
   );
   fp16_to_fixed_pipe #(.FRAC_BITS(16)) dut16 (
      .clk(clk), .rst(rst), .bus(b16)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic real pow2(input int k);
      real r = 1.0;
      for (int i = 0; i < k; i++) r = r * 2.0;
      for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   // Exact value as a real, scaled, then round-half-even by hand.
   function automatic res_t model(input logic [15:0] h, input int fb);
      res_t   o;
      real    x;
      real    y;
      real    fr;
      longint k;
      longint lim;
      int     e = int'(h[14:10]);
      int     m = int'(h[9:0]);
      lim = longint'(1) << fb;
      o.v = '0;
      o.f = 3'b000;
      if (e == 31) begin
         if (m != 0) o.f = 3'b100;
         else if (h[15]) o.f = 3'b001;
         else begin
            o.v = 64'(lim - 1);
            o.f = 3'b010;
         end
         return o;
      end
      x = (e == 0) ? m * pow2(-24) : (1024 + m) * pow2(e - 25);
      if (h[15] && x != 0.0) begin
         o.f = 3'b001;
         return o;
      end
      y  = x * pow2(fb);
      k  = longint'($floor(y));
      fr = y - real'(k);
      if (fr > 0.5 || (fr == 0.5 && k[0])) k++;
      if (k >= lim) begin
         o.v = 64'(lim - 1);
         o.f = 3'b010;
      end else begin
         o.v = 64'(k);
      end
      return o;
   endfunction

   function automatic logic [15:0] rnd_h();
      logic [15:0] h = 16'($urandom);
      case ($urandom_range(0, 3))
         0: h = h;
         1: h[14:10] = 5'($urandom_range(0, 14));
         2: h[14:10] = 5'($urandom_range(0, 4));
         default: begin
            h[15]    = 1'b0;
            h[14:10] = 5'($urandom_range(5, 15));
         end
      endcase
      return h;
   endfunction

   function automatic logic rdy(input int s);
      return (s == 0) ? b32.in_ready : b16.in_ready;
   endfunction

   function automatic logic ovld(input int s);
      return (s == 0) ? b32.out_valid : b16.out_valid;
   endfunction

   function automatic logic [63:0] oval(input int s);
      return (s == 0) ? 64'(b32.out_val) : 64'(b16.out_val);
   endfunction

   function automatic logic [2:0] oflg(input int s);
      return (s == 0) ? b32.out_flags : b16.out_flags;
   endfunction

   task automatic drive(input int s, input logic iv, input logic [15:0] h,
                        input logic orr);
      if (s == 0) begin
         b32.in_valid  = iv;
         b32.fp16_in   = h;
         b32.out_ready = orr;
      end else begin
         b16.in_valid  = iv;
         b16.fp16_in   = h;
         b16.out_ready = orr;
      end
   endtask

   task automatic mon(input int s, input logic iv, input logic ir,
                      input logic [15:0] h, input logic ov, input logic orr,
                      input logic [63:0] v, input logic [2:0] f);
      res_t r;
      if (hold[s]) begin
         check($sformatf("stall_valid%0d", s), 64'(ov), 64'd1);
         check($sformatf("stall_val%0d", s), v, hv[s]);
         check($sformatf("stall_flags%0d", s), 64'(f), 64'(hf[s]));
      end
      hold[s] = ov && !orr;
      hv[s]   = v;
      hf[s]   = f;
      if (iv && ir) begin
         if (s == 0) sb32.push_back(model(h, 32));
         else sb16.push_back(model(h, 16));
      end
      if (ov && orr) begin
         outs[s]++;
         if ((s == 0 && sb32.size() == 0) || (s == 1 && sb16.size() == 0)) begin
            check($sformatf("unexpected_out%0d", s), 64'(ov), 64'd0);
         end else begin
            if (s == 0) r = sb32.pop_front();
            else r = sb16.pop_front();
            check($sformatf("out_val%0d(in %0h)", s, 0), v, r.v);
            check($sformatf("out_flags%0d", s), 64'(f), 64'(r.f));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst || !mon_en) begin
         hold[0] = 1'b0;
         hold[1] = 1'b0;
      end else begin
         mon(0, b32.in_valid, b32.in_ready, b32.fp16_in, b32.out_valid,
             b32.out_ready, 64'(b32.out_val), b32.out_flags);
         mon(1, b16.in_valid, b16.in_ready, b16.fp16_in, b16.out_valid,
             b16.out_ready, 64'(b16.out_val), b16.out_flags);
      end
   end

   task automatic one(input vec_t t, input int idx);
      int   lat = 0;
      logic ov  = 1'b0;
      drive(t.sel, 1'b1, t.h, 1'b1);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", idx), 64'(rdy(t.sel)), 64'd1);
      @(posedge clk); #1;
      drive(t.sel, 1'b0, t.h, 1'b1);
      do begin
         @(negedge clk);
         lat++;
         ov = ovld(t.sel);
      end while (!ov && lat < 8);
      check($sformatf("vec%0d_latency", idx), 64'(lat), 64'd2);
      check($sformatf("vec%0d_val", idx), oval(t.sel), t.v);
      check($sformatf("vec%0d_flags", idx), 64'(oflg(t.sel)), 64'(t.f));
      @(posedge clk); #1;
   endtask

   task automatic stream(input int s, input int n, input int st, input int sl,
                         input bit rv, input bit rr, output int blocked,
                         output int firstc, output int lastc, output int in_cyc);
      int          sent = 0;
      int          base = outs[s];
      int          cyc  = 0;
      bit          fire;
      logic        iv;
      logic        orr;
      logic [15:0] cur = rnd_h();
      blocked = 0;
      firstc  = -1;
      lastc   = -1;
      in_cyc  = 0;
      while ((sent < n || outs[s] < base + n) && cyc < 1000) begin
         iv  = (sent < n) && (!rv || $urandom_range(0, 3) != 0);
         orr = !(cyc >= st && cyc < st + sl) && (!rr || $urandom_range(0, 3) != 0);
         drive(s, iv, cur, orr);
         @(negedge clk);
         fire = iv && rdy(s);
         if (!orr && !rdy(s)) blocked++;
         if (ovld(s) && orr) begin
            if (firstc < 0) firstc = cyc;
            lastc = cyc;
         end
         @(posedge clk); #1;
         if (fire) begin
            sent++;
            cur = rnd_h();
            if (sent == n) in_cyc = cyc + 1;
         end
         cyc++;
      end
      drive(s, 1'b0, cur, 1'b1);
      check($sformatf("stream%0d_count", s), 64'(outs[s] - base), 64'(n));
   endtask

   initial begin
      vec_t tv[$];
      int   blk, fc, lc, ic, ocnt;
      drive(0, 1'b0, 16'h0, 1'b0);
      drive(1, 1'b0, 16'h0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(b32.out_valid), 64'd0);
      check("rst_out_val", 64'(b32.out_val), 64'd0);
      check("rst_out_flags", 64'(b32.out_flags), 64'd0);
      check("rst_in_ready", 64'(b32.in_ready), 64'd1);
      check("rst_in_ready16", 64'(b16.in_ready), 64'd1);
      @(posedge clk); #1;

      tv.push_back('{16'h3800, 64'h8000_0000, 3'b000, 0});
      tv.push_back('{16'h3C00, 64'hFFFF_FFFF, 3'b010, 0});
      tv.push_back('{16'h7C00, 64'hFFFF_FFFF, 3'b010, 0});
      tv.push_back('{16'h7E00, 64'h0,         3'b100, 0});
      tv.push_back('{16'hB800, 64'h0,         3'b001, 0});
      tv.push_back('{16'h8000, 64'h0,         3'b000, 0});
      tv.push_back('{16'h0001, 64'h100,       3'b000, 0});
      tv.push_back('{16'hFC00, 64'h0,         3'b001, 0});
      tv.push_back('{16'h3BFF, 64'hFFE0_0000, 3'b000, 0});
      tv.push_back('{16'h7BFF, 64'hFFFF_FFFF, 3'b010, 0});
      tv.push_back('{16'h3555, 64'h5550,      3'b000, 1});
      tv.push_back('{16'h1C01, 64'h0100,      3'b000, 1});
      tv.push_back('{16'h1C02, 64'h0100,      3'b000, 1});
      tv.push_back('{16'h1C06, 64'h0102,      3'b000, 1});
      tv.push_back('{16'h0001, 64'h0,         3'b000, 1});
      tv.push_back('{16'h0080, 64'h0,         3'b000, 1});
      tv.push_back('{16'h0180, 64'h2,         3'b000, 1});
      tv.push_back('{16'h3BFF, 64'hFFE0,      3'b000, 1});
      tv.push_back('{16'h3C00, 64'hFFFF,      3'b010, 1});
      foreach (tv[i]) one(tv[i], i);

      mon_en = 1'b1;
      stream(0, 16, 0, 0, 1'b0, 1'b0, blk, fc, lc, ic);
      check("cont_in_cycles", 64'(ic), 64'd16);
      check("cont_out_span", 64'(lc - fc), 64'd15);
      stream(0, 8, 3, 5, 1'b0, 1'b0, blk, fc, lc, ic);
      check("bp_in_ready_drop", 64'(blk != 0), 64'd1);
      stream(1, 8, 2, 4, 1'b0, 1'b0, blk, fc, lc, ic);
      check("bp16_in_ready_drop", 64'(blk != 0), 64'd1);
      stream(0, 200, 0, 0, 1'b1, 1'b1, blk, fc, lc, ic);
      stream(1, 200, 0, 0, 1'b1, 1'b1, blk, fc, lc, ic);

      drive(0, 1'b1, 16'h3800, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b1, 16'h3555, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 16'h0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb32.delete();
      @(negedge clk);
      check("flush_out_valid", 64'(b32.out_valid), 64'd0);
      check("flush_out_val", 64'(b32.out_val), 64'd0);
      check("flush_out_flags", 64'(b32.out_flags), 64'd0);
      check("flush_in_ready", 64'(b32.in_ready), 64'd1);
      @(posedge clk); #1;
      drive(0, 1'b0, 16'h0, 1'b1);
      ocnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (b32.out_valid) ocnt++;
      end
      check("flush_no_stale", 64'(ocnt), 64'd0);
      @(posedge clk); #1;
      stream(0, 4, 0, 0, 1'b0, 1'b0, blk, fc, lc, ic);
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
